// File: rtl/ide_disk_target.sv
// ATA PIO drive-side target: task file, 256-word sector buffer, LBA READ/WRITE SECTOR(S)
// with sector data held in an external word-addressed backing store (req/ack).
module ide_disk_target #(
  parameter int LBA_W = 16,
  parameter int ST_AW = LBA_W + 8
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [15:0]      ide_data_bus,
  input  logic             ide_dior,
  input  logic             ide_diow,
  input  logic [1:0]       ide_cs,
  input  logic [2:0]       ide_da,
  output logic [ST_AW-1:0] st_addr,
  output logic             st_rd,
  output logic             st_wr,
  output logic [15:0]      st_data_out,
  input  logic [15:0]      st_data_in,
  input  logic             st_ack,
  output logic [2:0]       dbg_state,
  output logic             dbg_bus_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRQ_RD, S_DRQ_WR, S_FLUSH, S_NEXT, S_ABORT
  } state_t;

  // Store handshake: st_rd/st_wr is held high until the one-cycle st_ack, then
  // dropped for at least one cycle, so only one store request is ever in flight.
  state_t      state;
  logic [7:0]  status_r, error_r, count_r, lba_l, lba_m, lba_h, dev_r;
  logic [7:0]  idx;
  logic        is_wr, srst_pend;
  logic        dior_q, diow_q;
  logic [1:0]  cs_q;
  logic [2:0]  da_q;
  logic [15:0] data_q;
  logic [15:0] sbuf [256];

  logic [27:0] lba28, lba_inc;
  logic        lba_bad;
  logic        wr_ev, rd_ev, cmd_wr, ctl_wr, data_wr, data_rd;
  logic        buf_we;
  logic [15:0] buf_wd;
  logic [15:0] rd_val;
  logic        bus_oe;

  assign lba28   = {dev_r[3:0], lba_h, lba_m, lba_l};
  assign lba_inc = lba28 + 28'd1;
  assign lba_bad = (lba28 >> LBA_W) != 28'd0;

  // Host cycles are recognised on the strobe rising edge; address and data come
  // from the sample taken one clock earlier, while the strobe was still low.
  assign wr_ev   = !diow_q && ide_diow;
  assign rd_ev   = !dior_q && ide_dior;
  assign cmd_wr  = wr_ev && (cs_q == 2'b10);
  assign ctl_wr  = wr_ev && (cs_q == 2'b01) && (da_q == 3'd6);
  assign data_wr = cmd_wr && (da_q == 3'd0);
  assign data_rd = rd_ev && (cs_q == 2'b10) && (da_q == 3'd0);

  assign dbg_state  = state;
  assign dbg_bus_oe = bus_oe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dior_q <= 1'b1;
      diow_q <= 1'b1;
      cs_q   <= 2'b11;
      da_q   <= 3'd0;
      data_q <= 16'h0000;
    end else begin
      dior_q <= ide_dior;
      diow_q <= ide_diow;
      cs_q   <= ide_cs;
      da_q   <= ide_da;
      data_q <= ide_data_bus;
    end
  end

  always_comb begin
    buf_we = 1'b0;
    buf_wd = 16'h0000;
    if (state == S_FETCH && st_rd && st_ack) begin
      buf_we = 1'b1;
      buf_wd = st_data_in;
    end else if (state == S_DRQ_WR && data_wr) begin
      buf_we = 1'b1;
      buf_wd = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) sbuf[idx] <= buf_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      status_r    <= 8'h50;
      error_r     <= 8'h01;
      count_r     <= 8'h01;
      lba_l       <= 8'h00;
      lba_m       <= 8'h00;
      lba_h       <= 8'h00;
      dev_r       <= 8'h00;
      idx         <= 8'h00;
      is_wr       <= 1'b0;
      srst_pend   <= 1'b0;
      st_rd       <= 1'b0;
      st_wr       <= 1'b0;
      st_addr     <= '0;
      st_data_out <= 16'h0000;
    end else if (srst_pend) begin
      state       <= S_IDLE;
      status_r    <= 8'h50;
      error_r     <= 8'h01;
      count_r     <= 8'h01;
      lba_l       <= 8'h00;
      lba_m       <= 8'h00;
      lba_h       <= 8'h00;
      dev_r       <= 8'h00;
      idx         <= 8'h00;
      is_wr       <= 1'b0;
      srst_pend   <= 1'b0;
      st_rd       <= 1'b0;
      st_wr       <= 1'b0;
      st_addr     <= '0;
      st_data_out <= 16'h0000;
    end else begin
      if (ctl_wr && data_q[2]) srst_pend <= 1'b1;
      if (cmd_wr) begin
        case (da_q)
          3'd2:    count_r <= data_q[7:0];
          3'd3:    lba_l   <= data_q[7:0];
          3'd4:    lba_m   <= data_q[7:0];
          3'd5:    lba_h   <= data_q[7:0];
          3'd6:    dev_r   <= data_q[7:0];
          default: ;
        endcase
      end
      case (state)
        S_IDLE: begin
          if (cmd_wr && da_q == 3'd7 && !status_r[7] && !status_r[3]) begin
            case (data_q[7:0])
              8'h20, 8'h21, 8'h30, 8'h31: begin
                if (lba_bad) begin
                  error_r  <= 8'h10;
                  status_r <= 8'h51;
                  state    <= S_ABORT;
                end else begin
                  is_wr <= data_q[4];
                  idx   <= 8'h00;
                  if (data_q[4]) begin
                    status_r <= 8'h58;
                    state    <= S_DRQ_WR;
                  end else begin
                    status_r <= 8'h90;
                    state    <= S_FETCH;
                  end
                end
              end
              8'hE7: status_r <= 8'h50;
              default: begin
                error_r  <= 8'h04;
                status_r <= 8'h51;
                state    <= S_ABORT;
              end
            endcase
          end
        end
        S_FETCH: begin
          if (st_rd) begin
            if (st_ack) begin
              st_rd <= 1'b0;
              idx   <= idx + 8'd1;
              if (idx == 8'hFF) begin
                status_r <= 8'h58;
                state    <= S_DRQ_RD;
              end
            end
          end else begin
            st_rd   <= 1'b1;
            st_addr <= {lba28[LBA_W-1:0], idx};
          end
        end
        S_DRQ_RD: begin
          if (data_rd) begin
            idx <= idx + 8'd1;
            if (idx == 8'hFF) begin
              status_r <= 8'hD0;
              state    <= S_NEXT;
            end
          end
        end
        S_DRQ_WR: begin
          if (data_wr) begin
            idx <= idx + 8'd1;
            if (idx == 8'hFF) begin
              status_r <= 8'hD0;
              state    <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (st_wr) begin
            if (st_ack) begin
              st_wr <= 1'b0;
              idx   <= idx + 8'd1;
              if (idx == 8'hFF) state <= S_NEXT;
            end
          end else begin
            st_wr       <= 1'b1;
            st_addr     <= {lba28[LBA_W-1:0], idx};
            st_data_out <= sbuf[idx];
          end
        end
        S_NEXT: begin
          count_r    <= count_r - 8'd1;
          lba_l      <= lba_inc[7:0];
          lba_m      <= lba_inc[15:8];
          lba_h      <= lba_inc[23:16];
          dev_r[3:0] <= lba_inc[27:24];
          if (count_r == 8'd1) begin
            status_r <= 8'h50;
            error_r  <= 8'h00;
            state    <= S_IDLE;
          end else if (is_wr) begin
            status_r <= 8'h58;
            state    <= S_DRQ_WR;
          end else begin
            status_r <= 8'h90;
            state    <= S_FETCH;
          end
        end
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = 16'h0000;
    bus_oe = 1'b0;
    if (!ide_dior) begin
      if (ide_cs == 2'b10) begin
        bus_oe = 1'b1;
        case (ide_da)
          3'd0:    rd_val = (state == S_DRQ_RD) ? sbuf[idx] : 16'h0000;
          3'd1:    rd_val = {8'h00, error_r};
          3'd2:    rd_val = {8'h00, count_r};
          3'd3:    rd_val = {8'h00, lba_l};
          3'd4:    rd_val = {8'h00, lba_m};
          3'd5:    rd_val = {8'h00, lba_h};
          3'd6:    rd_val = {8'h00, dev_r};
          default: rd_val = {8'h00, status_r};
        endcase
      end else if (ide_cs == 2'b01 && ide_da == 3'd6) begin
        bus_oe = 1'b1;
        rd_val = {8'h00, status_r};
      end
    end
  end

  assign ide_data_bus = bus_oe ? rd_val : 16'hzzzz;

endmodule

// File: tb/tb_ide_disk_target.sv
// Directed bench for ide_disk_target: host PIO driver tasks plus a backing-store responder.
module tb_ide_disk_target;

  localparam int LBA_W = 16;
  localparam int ST_AW = LBA_W + 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  wire  [15:0]      ide_data_bus;
  logic             ide_dior = 1'b1;
  logic             ide_diow = 1'b1;
  logic [1:0]       ide_cs = 2'b11;
  logic [2:0]       ide_da = 3'd0;
  logic [ST_AW-1:0] st_addr;
  logic             st_rd, st_wr;
  logic [15:0]      st_data_out;
  logic [15:0]      st_data_in = 16'h0000;
  logic             st_ack = 1'b0;
  logic [2:0]       dbg_state;
  logic             dbg_bus_oe;

  logic             tb_oe = 1'b0;
  logic [15:0]      tb_data = 16'h0000;
  assign ide_data_bus = tb_oe ? tb_data : 16'hzzzz;

  int checks = 0;
  int failures = 0;
  logic [15:0] mem [int];
  int  wr_acks = 0;
  bit  ack_hold = 1'b0;
  bit  rd_seen = 1'b0;
  int  lat_cnt = 0;

  ide_disk_target #(.LBA_W(LBA_W), .ST_AW(ST_AW)) dut (
    .clk(clk), .reset(reset), .ide_data_bus(ide_data_bus),
    .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da),
    .st_addr(st_addr), .st_rd(st_rd), .st_wr(st_wr), .st_data_out(st_data_out),
    .st_data_in(st_data_in), .st_ack(st_ack),
    .dbg_state(dbg_state), .dbg_bus_oe(dbg_bus_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Backing store: acks each request one-cycle wide after a short latency.
  initial begin
    forever begin
      @(negedge clk);
      if (st_rd) rd_seen = 1'b1;
      if (st_ack) begin
        st_ack = 1'b0;
      end else if ((st_rd || st_wr) && !ack_hold && reset) begin
        if (lat_cnt >= 1) begin
          lat_cnt = 0;
          st_ack  = 1'b1;
          if (st_rd) begin
            st_data_in = mem.exists(int'(st_addr)) ? mem[int'(st_addr)] : 16'h0000;
          end else begin
            mem[int'(st_addr)] = st_data_out;
            wr_acks++;
          end
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] cs, input logic [2:0] da, output logic [15:0] v);
    @(negedge clk);
    ide_cs = cs; ide_da = da; ide_dior = 1'b0;
    @(negedge clk);
    @(negedge clk);
    v = ide_data_bus;
    ide_dior = 1'b1;
    @(negedge clk);
    ide_cs = 2'b11;
  endtask

  task automatic do_write(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
    @(negedge clk);
    ide_cs = cs; ide_da = da; tb_data = d; tb_oe = 1'b1; ide_diow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ide_diow = 1'b1;
    @(negedge clk);
    tb_oe = 1'b0; ide_cs = 2'b11;
  endtask

  task automatic poll_status(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    v = 16'hFFFF;
    for (int n = 0; n < 1000; n++) begin
      do_read(2'b10, 3'd7, v);
      if (v == exp) break;
    end
    check(tag, v, exp);
  endtask

  task automatic set_lba_count(input logic [7:0] l, input logic [7:0] h, input logic [7:0] cnt);
    do_write(2'b10, 3'd3, {8'h00, l});
    do_write(2'b10, 3'd4, 16'h0000);
    do_write(2'b10, 3'd5, {8'h00, h});
    do_write(2'b10, 3'd6, 16'h0040);
    do_write(2'b10, 3'd2, {8'h00, cnt});
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) mem[5 * 256 + i] = 16'(i) ^ 16'hA5A5;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_state", dbg_state, 3'd0);
    check("rst_st_rd", st_rd, 1'b0);
    check("rst_st_wr", st_wr, 1'b0);
    check("rst_st_addr", st_addr, 24'h0);
    check("rst_st_data_out", st_data_out, 16'h0);
    check("rst_bus_oe", dbg_bus_oe, 1'b0);
    do_read(2'b10, 3'd7, v); check("rst_status", v, 16'h0050);
    do_read(2'b10, 3'd2, v); check("rst_count", v, 16'h0001);
    do_read(2'b10, 3'd1, v); check("rst_error", v, 16'h0001);
    do_read(2'b01, 3'd6, v); check("rst_altstatus", v, 16'h0050);
    do_read(2'b10, 3'd0, v); check("idle_data_read", v, 16'h0000);

    // Single-sector read of LBA 5.
    set_lba_count(8'd5, 8'd0, 8'd1);
    do_write(2'b10, 3'd7, 16'h0020);
    poll_status("rd1_drq", 16'h0058);
    for (int i = 0; i < 256; i++) begin
      do_read(2'b10, 3'd0, v);
      check($sformatf("rd1_word%0d", i), v, 16'(i) ^ 16'hA5A5);
    end
    poll_status("rd1_done", 16'h0050);
    do_read(2'b10, 3'd1, v); check("rd1_error", v, 16'h0000);
    do_read(2'b10, 3'd3, v); check("rd1_lba", v, 16'h0006);
    do_read(2'b10, 3'd2, v); check("rd1_count", v, 16'h0000);

    // Two-sector write at LBA 0, word k = k.
    wr_acks = 0;
    set_lba_count(8'd0, 8'd0, 8'd2);
    do_write(2'b10, 3'd7, 16'h0030);
    for (int s = 0; s < 2; s++) begin
      poll_status($sformatf("wr_drq%0d", s), 16'h0058);
      for (int i = 0; i < 256; i++) do_write(2'b10, 3'd0, 16'(s * 256 + i));
    end
    poll_status("wr_done", 16'h0050);
    check("wr_ack_count", wr_acks, 512);
    for (int k = 0; k < 512; k++)
      check($sformatf("wr_mem%0d", k), mem.exists(k) ? mem[k] : 16'hDEAD, 16'(k));
    do_read(2'b10, 3'd3, v); check("wr_lba", v, 16'h0002);
    do_read(2'b10, 3'd2, v); check("wr_count", v, 16'h0000);

    // Unsupported opcode, then a normal read.
    do_write(2'b10, 3'd7, 16'h0091);
    do_read(2'b10, 3'd7, v); check("bad_cmd_status", v, 16'h0051);
    do_read(2'b10, 3'd1, v); check("bad_cmd_error", v, 16'h0004);
    set_lba_count(8'd5, 8'd0, 8'd1);
    do_write(2'b10, 3'd7, 16'h0020);
    poll_status("rd2_drq", 16'h0058);
    for (int i = 0; i < 256; i++) begin
      do_read(2'b10, 3'd0, v);
      check($sformatf("rd2_word%0d", i), v, 16'(i) ^ 16'hA5A5);
    end
    poll_status("rd2_done", 16'h0050);

    // LBA beyond capacity.
    set_lba_count(8'd5, 8'h01, 8'd1);
    rd_seen = 1'b0;
    do_write(2'b10, 3'd7, 16'h0020);
    repeat (4) @(negedge clk);
    do_read(2'b10, 3'd7, v); check("range_status", v, 16'h0051);
    do_read(2'b10, 3'd1, v); check("range_error", v, 16'h0010);
    check("range_no_st_rd", rd_seen, 1'b0);

    // Soft reset mid-FETCH with the store stalled.
    set_lba_count(8'd5, 8'd0, 8'd1);
    ack_hold = 1'b1;
    do_write(2'b10, 3'd7, 16'h0020);
    repeat (3) @(negedge clk);
    check("srst_in_fetch", dbg_state, 3'd1);
    check("srst_st_rd_high", st_rd, 1'b1);
    do_write(2'b01, 3'd6, 16'h0004);
    @(negedge clk);
    check("srst_st_rd_drop", st_rd, 1'b0);
    check("srst_state", dbg_state, 3'd0);
    ack_hold = 1'b0;
    do_read(2'b10, 3'd7, v); check("srst_status", v, 16'h0050);
    do_read(2'b10, 3'd1, v); check("srst_error", v, 16'h0001);
    do_read(2'b10, 3'd3, v); check("srst_lba_clear", v, 16'h0000);

    // Hard reset mid-DRQ_RD.
    set_lba_count(8'd5, 8'd0, 8'd1);
    do_write(2'b10, 3'd7, 16'h0020);
    poll_status("hrst_drq", 16'h0058);
    for (int i = 0; i < 10; i++) do_read(2'b10, 3'd0, v);
    check("hrst_word9", v, 16'd9 ^ 16'hA5A5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("hrst_bus_oe", dbg_bus_oe, 1'b0);
    check("hrst_st_rd", st_rd, 1'b0);
    check("hrst_state", dbg_state, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    do_read(2'b10, 3'd7, v); check("hrst_status", v, 16'h0050);
    do_read(2'b10, 3'd2, v); check("hrst_count", v, 16'h0001);
    @(negedge clk);
    check("hrst_bus_idle", dbg_bus_oe, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ide_disk_target.md
Name: ide_disk_target

Overview:
- Synthesizable ATA PIO device (drive side) that answers the IDE host interface (ide_data_bus, ide_dior, ide_diow, ide_cs, ide_da) driven by the rk_regs IDE controller.
- Implements the task file, a 256-word sector buffer, and READ/WRITE SECTOR(S) in LBA mode.
- Sector contents live in an external word-addressed backing store reached through a req/ack port.
- Lets simulation and FPGA builds run without the $pli_ide model.

Parameters:
LBA_W, 16, implemented LBA bits; capacity is 2**LBA_W sectors.
ST_AW, LBA_W+8, backing-store word address width (LBA concatenated with word index).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ide_data_bus  inout  16  driven by target only while a data/register read is active, else Z
ide_dior  in  1  read strobe, active low
ide_diow  in  1  write strobe, active low
ide_cs  in  2  active-low chip selects; [0]=command block, [1]=control block
ide_da  in  3  register address
st_addr  out  ST_AW  backing-store word address
st_rd  out  1  store read request
st_wr  out  1  store write request
st_data_out  out  16  write data to store
st_data_in  in  16  read data from store, valid with st_ack
st_ack  in  1  one-cycle store completion

Behaviour:
- Strobes are sampled each clk. A write is captured on the cycle the sampled ide_diow goes 0->1 (data and address sampled on the previous cycle). A read drives data while ide_dior=0 and a valid register is selected; read side effects occur on the dior 0->1 edge.
- Command block registers (cs=2'b10):
  - da0 = data, 16 bit.
  - da1 = error (read) / features (write, ignored).
  - da2 = sector count; 0 means 256.
  - da3/4/5 = LBA[7:0]/[15:8]/[23:16].
  - da6 = device; LBA[27:24] in [3:0].
  - da7 = status (read) / command (write).
- Control block (cs=2'b01): da6 read = alt status, same value as status. da6 write = device control; bit2 SRST=1 forces soft reset.
- Register reads return 8-bit values zero-extended.
- Status bits: BSY 0x80, DRDY 0x40, DSC 0x10, DRQ 0x08, ERR 0x01.
- Reset values: status 0x50, error 0x01, all task-file registers 0, sector count 1, st_rd=st_wr=0, st_addr=0, st_data_out=0, data bus Z, FSM IDLE. Soft reset gives the same result except data bus already Z.
- FSM states: IDLE, FETCH, DRQ_RD, DRQ_WR, FLUSH, NEXT, ABORT.
- IDLE, command write:
  - 0x20/0x21 -> status 0x90, FETCH.
  - 0x30/0x31 -> status 0x58 (DRQ, BSY clear), DRQ_WR.
  - 0xE7 -> status 0x50 after 1 cycle.
  - Any other opcode -> ABORT: error 0x04, status 0x51.
  - Any LBA bit at or above LBA_W set on a read/write command -> error 0x10, status 0x51.
  - Command writes while BSY or DRQ are ignored.
- FETCH:
  - Issue st_rd with st_addr={lba,word}.
  - On st_ack, store the word into the buffer and increment word; one request outstanding at a time.
  - After word 255 -> DRQ_RD, status 0x58, buffer pointer 0.
- DRQ_RD: each data-register read returns buffer[ptr]; ptr++ on the dior rising edge. After the 256th read -> NEXT.
- DRQ_WR: each data-register write stores buffer[ptr], ptr++. After the 256th -> FLUSH, status 0xD0.
- FLUSH: st_wr per word with st_data_out=buffer[word]; advance on st_ack; after word 255 -> NEXT.
- NEXT (one cycle):
  - Decrement sector count (8-bit wrap; 0 start = 256 sectors) and increment the 28-bit LBA in the task file.
  - If the count reaches 0: status 0x50, error 0x00, IDLE.
  - Otherwise read commands -> FETCH (BSY), write commands -> DRQ_WR.
- Data-register accesses outside DRQ_RD/DRQ_WR: reads return 0, writes are ignored, pointer unchanged.
- Asynchronous reset mid-transfer abandons the sector immediately: st_rd/st_wr drop, no further store cycles.
- Soft reset is applied on the cycle after the control write and also abandons any transfer.

Test Plan:
- Reset, then read status (cs=10, da=7) -> 0x0050. Read sector count -> 1.
- Preload store sector 5 with word i = i^16'hA5A5. Write LBA=5, count=1, cmd 0x20. Poll until status 0x58, then 256 data reads -> word i returned in order; final status 0x50.
- count=2, LBA=0, cmd 0x30; write 512 words of value k. Store words 0..511 must hold k; exactly 512 st_wr acks; LBA register ends at 2, count 0.
- cmd 0x91 -> status 0x51, error 0x04. Then a valid 0x20 succeeds normally.
- LBA high byte 0x01 with LBA_W=16, cmd 0x20 -> status 0x51, error 0x10, no st_rd issued.
- Start cmd 0x20, delay st_ack, write device control 0x04 mid-FETCH -> st_rd drops, status 0x50. Repeat with the reset pin held low mid-DRQ_RD -> bus Z, status 0x50.
